// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: reads imem at the current PC, presents {instr, pc} to decode
// over a valid/ready handshake with a one-entry skid buffer, and drives the PC operand
// (the PC register always loads pc_feed + 1).
// Optional feature macro: FETCH_HALT_EN -- an all-ones instruction halts fetching.
module instr_fetch_stage #(
    parameter int ADDR_W  = 6,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic [ADDR_W-1:0]  pc_feed,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic               imem_rd_en,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc,
    output logic               halted
);

    typedef enum logic [1:0] {RUN, STALL, HALT} state_t;

    state_t             state_q;
    logic               outValid_q;
    logic [INSTR_W-1:0] outInstr_q;
    logic [ADDR_W-1:0]  outPc_q;
    logic               skidValid_q;
    logic [INSTR_W-1:0] skidInstr_q;
    logic [ADDR_W-1:0]  skidPc_q;
    logic               inflight_q;
    logic [ADDR_W-1:0]  inflightPc_q;

    logic               consume;
    logic               issueOk;
    logic               issue;
    logic               rdataLive;
    logic               loadsOut;
    logic [INSTR_W-1:0] loadInstr;
    logic               haltLoad;

    // Handshake and issue qualification; a read may only start if its data has somewhere to land
    assign consume   = outValid_q && id_ready;
    assign issueOk   = !redirect_valid && !skidValid_q && !(inflight_q && outValid_q && !id_ready);
    assign issue     = !reset && issueOk && (state_q != HALT);
    assign rdataLive = inflight_q && (state_q != HALT);

    assign imem_addr  = pc_in;
    assign imem_rd_en = issue;

    assign id_valid = outValid_q;
    assign id_instr = outInstr_q;
    assign id_pc    = outPc_q;

    // Which word lands in the output register this cycle (skid has priority over fresh data)
    assign loadInstr = skidValid_q ? skidInstr_q : imem_rdata;
    assign loadsOut  = skidValid_q ? consume : (rdataLive && (!outValid_q || consume));

`ifdef FETCH_HALT_EN
    assign haltLoad = loadsOut && (loadInstr == {INSTR_W{1'b1}});
    assign halted   = (state_q == HALT);
`else
    assign haltLoad = 1'b0;
    assign halted   = 1'b0;
`endif

    // PC operand: the PC adds one, so advancing feeds pc_in, holding feeds pc_in-1
    always_comb begin
        pc_feed = pc_in - ADDR_W'(1);
        if (reset) begin
            pc_feed = '0;
        end else if (redirect_valid) begin
            pc_feed = redirect_target - ADDR_W'(1);
        end else if (issue) begin
            pc_feed = pc_in;
        end
    end

    // Fetch pipeline state: in-flight read, output register, skid entry and FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            outValid_q   <= 1'b0;
            outInstr_q   <= '0;
            outPc_q      <= '0;
            skidValid_q  <= 1'b0;
            skidInstr_q  <= '0;
            skidPc_q     <= '0;
            inflight_q   <= 1'b0;
            inflightPc_q <= '0;
        end else if (redirect_valid) begin
            state_q     <= RUN;
            outValid_q  <= 1'b0;
            skidValid_q <= 1'b0;
            inflight_q  <= 1'b0;
        end else begin
            inflight_q   <= issue;
            inflightPc_q <= pc_in;
            if (skidValid_q) begin
                if (consume) begin
                    outValid_q  <= 1'b1;
                    outInstr_q  <= skidInstr_q;
                    outPc_q     <= skidPc_q;
                    skidValid_q <= 1'b0;
                end
            end else if (rdataLive) begin
                if (!outValid_q || consume) begin
                    outValid_q <= 1'b1;
                    outInstr_q <= imem_rdata;
                    outPc_q    <= inflightPc_q;
                end else begin
                    skidValid_q <= 1'b1;
                    skidInstr_q <= imem_rdata;
                    skidPc_q    <= inflightPc_q;
                end
            end else if (consume) begin
                outValid_q <= 1'b0;
            end
            if (state_q != HALT) begin
                if (haltLoad) begin
                    state_q <= HALT;
                end else if (issueOk) begin
                    state_q <= RUN;
                end else begin
                    state_q <= STALL;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: models the external PC register and a
// one-cycle-latency instruction memory, and scores delivered {pc, instr} pairs
// against a queue of expected PCs.
module tb_instr_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  pcReg;
    logic [5:0]  pc_feed;
    logic [5:0]  imem_addr;
    logic        imem_rd_en;
    logic [15:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [5:0]  redirect_target = '0;
    logic        id_valid;
    logic        id_ready = 1'b1;
    logic [15:0] id_instr;
    logic [5:0]  id_pc;
    logic        halted;

    logic [15:0] mem [64];
    logic [5:0]  expPc [$];
    int          totalCnt = 0;
    int          badCnt = 0;

    instr_fetch_stage #(.ADDR_W(6), .INSTR_W(16)) dut (
        .clk(clk), .reset(reset), .pc_in(pcReg), .pc_feed(pc_feed),
        .imem_addr(imem_addr), .imem_rd_en(imem_rd_en), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
        .id_pc(id_pc), .halted(halted)
    );

    always #5 clk = ~clk;

    // External program counter: synchronous reset to 0, otherwise loads pc_feed + 1
    always @(posedge clk) pcReg <= reset ? 6'd0 : 6'(pc_feed + 6'd1);

    // Instruction memory with one cycle of read latency
    always @(posedge clk) if (imem_rd_en) imem_rdata <= mem[imem_addr];

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic runStream(input int budget);
        int cyc;
        logic [5:0] e;
        cyc = 0;
        while (expPc.size() > 0 && cyc < budget) begin
            if (id_valid && id_ready) begin
                e = expPc.pop_front();
                totalCnt += 2;
                if (id_pc !== e) begin
                    badCnt++;
                    $display("[TB] FAIL stream_pc got=%0d want=%0d", id_pc, e);
                end
                if (id_instr !== mem[e]) begin
                    badCnt++;
                    $display("[TB] FAIL stream_instr got=%h want=%h", id_instr, mem[e]);
                end
            end
            nextCycle();
            cyc++;
        end
        if (expPc.size() != 0) begin
            totalCnt++;
            badCnt++;
            $display("[TB] FAIL stream_timeout pending=%0d want=0", expPc.size());
            expPc.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        redirect_valid = 1'b0;
        id_ready = 1'b1;
        nextCycle();
        nextCycle();
        #1;
        totalCnt += 6;
        if (id_valid !== 1'b0) begin badCnt++; $display("[TB] FAIL rst_valid got=%b want=0", id_valid); end
        if (id_pc !== 6'd0) begin badCnt++; $display("[TB] FAIL rst_pc got=%0d want=0", id_pc); end
        if (id_instr !== 16'd0) begin badCnt++; $display("[TB] FAIL rst_instr got=%h want=0", id_instr); end
        if (halted !== 1'b0) begin badCnt++; $display("[TB] FAIL rst_halted got=%b want=0", halted); end
        if (imem_rd_en !== 1'b0) begin badCnt++; $display("[TB] FAIL rst_rden got=%b want=0", imem_rd_en); end
        if (pc_feed !== 6'd0) begin badCnt++; $display("[TB] FAIL rst_feed got=%0d want=0", pc_feed); end
        reset = 1'b0;
        #1;
        totalCnt += 2;
        if (imem_rd_en !== 1'b1) begin badCnt++; $display("[TB] FAIL first_issue got=%b want=1", imem_rd_en); end
        if (imem_addr !== 6'd0) begin badCnt++; $display("[TB] FAIL first_addr got=%0d want=0", imem_addr); end
    endtask

    task automatic test_first_fetch();
        nextCycle();
        totalCnt++;
        if (id_valid !== 1'b0) begin badCnt++; $display("[TB] FAIL latency_early got=%b want=0", id_valid); end
        nextCycle();
        for (int i = 0; i < 4; i++) begin
            totalCnt += 3;
            if (id_valid !== 1'b1) begin badCnt++; $display("[TB] FAIL seq_valid got=%b want=1", id_valid); end
            if (id_pc !== 6'(i)) begin badCnt++; $display("[TB] FAIL seq_pc got=%0d want=%0d", id_pc, i); end
            if (id_instr !== 16'h0100 + 16'(i)) begin
                badCnt++;
                $display("[TB] FAIL seq_instr got=%h want=%h", id_instr, 16'h0100 + 16'(i));
            end
            nextCycle();
        end
    endtask

    task automatic test_backpressure();
        int guard;
        guard = 0;
        while (!(id_valid && id_pc == 6'd5) && guard < 10) begin
            nextCycle();
            guard++;
        end
        id_ready = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            totalCnt += 4;
            if (id_valid !== 1'b1 || id_pc !== 6'd5) begin
                badCnt++;
                $display("[TB] FAIL bp_hold_pc got=%b/%0d want=1/5", id_valid, id_pc);
            end
            if (id_instr !== 16'h0105) begin badCnt++; $display("[TB] FAIL bp_hold_instr got=%h want=0105", id_instr); end
            if (imem_rd_en !== 1'b0) begin badCnt++; $display("[TB] FAIL bp_rden got=%b want=0", imem_rd_en); end
            if (pcReg !== 6'd7) begin badCnt++; $display("[TB] FAIL bp_pc_hold got=%0d want=7", pcReg); end
            nextCycle();
            #1;
        end
        id_ready = 1'b1;
        for (int p = 5; p < 10; p++) expPc.push_back(6'(p));
        runStream(30);
    endtask

    task automatic test_redirect();
        nextCycle();
        nextCycle();
        redirect_valid = 1'b1;
        redirect_target = 6'h20;
        #1;
        totalCnt += 2;
        if (pc_feed !== 6'h1F) begin badCnt++; $display("[TB] FAIL redir_feed got=%h want=1f", pc_feed); end
        if (imem_rd_en !== 1'b0) begin badCnt++; $display("[TB] FAIL redir_rden got=%b want=0", imem_rd_en); end
        nextCycle();
        redirect_valid = 1'b0;
        totalCnt++;
        if (id_valid !== 1'b0) begin badCnt++; $display("[TB] FAIL redir_flush got=%b want=0", id_valid); end
        nextCycle();
        nextCycle();
        totalCnt++;
        if (id_valid !== 1'b1 || id_pc !== 6'h20) begin
            badCnt++;
            $display("[TB] FAIL redir_target got=%b/%h want=1/20", id_valid, id_pc);
        end
        for (int p = 32; p < 37; p++) expPc.push_back(6'(p));
        runStream(20);
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1;
        redirect_target = 6'd62;
        nextCycle();
        redirect_valid = 1'b0;
        expPc.push_back(6'd62); expPc.push_back(6'd63);
        expPc.push_back(6'd0);  expPc.push_back(6'd1); expPc.push_back(6'd2);
        runStream(20);
        redirect_valid = 1'b1;
        redirect_target = 6'd0;
        #1;
        totalCnt++;
        if (pc_feed !== 6'd63) begin badCnt++; $display("[TB] FAIL wrap_redir_feed got=%0d want=63", pc_feed); end
        nextCycle();
        redirect_target = 6'd62;
        id_ready = 1'b0;
        nextCycle();
        redirect_valid = 1'b0;
        nextCycle();
        nextCycle();
        for (int k = 0; k < 2; k++) begin
            #1;
            totalCnt += 3;
            if (pcReg !== 6'd0) begin badCnt++; $display("[TB] FAIL wrap_stall_pc got=%0d want=0", pcReg); end
            if (pc_feed !== 6'd63) begin badCnt++; $display("[TB] FAIL wrap_stall_feed got=%0d want=63", pc_feed); end
            if (imem_rd_en !== 1'b0) begin badCnt++; $display("[TB] FAIL wrap_stall_rden got=%b want=0", imem_rd_en); end
            if (k == 0) nextCycle();
        end
        id_ready = 1'b1;
        expPc.push_back(6'd62); expPc.push_back(6'd63);
        expPc.push_back(6'd0);  expPc.push_back(6'd1);
        runStream(20);
    endtask

    task automatic test_reset_mid();
        id_ready = 1'b0;
        nextCycle();
        nextCycle();
        nextCycle();
        reset = 1'b1;
        #1;
        totalCnt += 2;
        if (imem_rd_en !== 1'b0) begin badCnt++; $display("[TB] FAIL midrst_rden got=%b want=0", imem_rd_en); end
        if (pc_feed !== 6'd0) begin badCnt++; $display("[TB] FAIL midrst_feed got=%0d want=0", pc_feed); end
        nextCycle();
        reset = 1'b0;
        id_ready = 1'b1;
        totalCnt++;
        if (id_valid !== 1'b0) begin badCnt++; $display("[TB] FAIL midrst_valid got=%b want=0", id_valid); end
        for (int p = 0; p < 4; p++) expPc.push_back(6'(p));
        runStream(20);
    endtask

    task automatic test_halt();
        mem[4] = 16'hFFFF;
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        for (int p = 0; p < 5; p++) expPc.push_back(6'(p));
        runStream(20);
`ifdef FETCH_HALT_EN
        for (int k = 0; k < 3; k++) begin
            #1;
            totalCnt += 4;
            if (id_valid !== 1'b0) begin badCnt++; $display("[TB] FAIL halt_valid got=%b want=0", id_valid); end
            if (halted !== 1'b1) begin badCnt++; $display("[TB] FAIL halt_flag got=%b want=1", halted); end
            if (imem_rd_en !== 1'b0) begin badCnt++; $display("[TB] FAIL halt_rden got=%b want=0", imem_rd_en); end
            if (pcReg !== 6'd6) begin badCnt++; $display("[TB] FAIL halt_pc got=%0d want=6", pcReg); end
            nextCycle();
        end
        redirect_valid = 1'b1;
        redirect_target = 6'd8;
        nextCycle();
        redirect_valid = 1'b0;
        totalCnt++;
        if (halted !== 1'b0) begin badCnt++; $display("[TB] FAIL halt_exit got=%b want=0", halted); end
        for (int p = 8; p < 11; p++) expPc.push_back(6'(p));
        runStream(20);
`else
        expPc.push_back(6'd5);
        expPc.push_back(6'd6);
        runStream(20);
        totalCnt++;
        if (halted !== 1'b0) begin badCnt++; $display("[TB] FAIL nohalt_flag got=%b want=0", halted); end
`endif
    endtask

    // Test sequence
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h0100 + 16'(i);
        test_reset();
        test_first_fetch();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_reset_mid();
        test_halt();
        $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
        $finish;
    end

endmodule
